// File: rtl/result_reader.sv
// result_reader: drains the PUF result memory and frames it as
// SOF, length, data bytes and checksum on a valid/ready byte stream.
module result_reader #(
  parameter int         ADDR_WIDTH = 13,
  parameter int         RD_LAT     = 1,
  parameter logic [7:0] SOF        = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  test_done,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [7:0]            mem_dout,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  frame_done
);

  typedef enum logic [3:0] {
    IDLE,
    HDR,
    LENH,
    LENL,
    RD,
    WAIT,
    DATA,
    CSUM,
    ARM
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ONE =
    ADDR_WIDTH'(1);
  localparam logic [1:0] WAIT_INIT =
    2'(RD_LAT - 1);

  state_t                state;
  logic [2:0]            sync;
  logic [ADDR_WIDTH-1:0] len;
  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0]            csum;
  logic [1:0]            wcnt;

  logic                  trig;
  logic                  accept;
  logic [7:0]            len_hi;
  logic [7:0]            len_lo;
  logic [7:0]            csum_add;

  // sync[1] is the synchronized level; sync[2] is its
  // previous value for rising-edge detection.
  assign trig     = sync[1] & ~sync[2];
  assign accept   = tx_valid & tx_ready;
  assign len_hi   = 8'(len >> 8);
  assign len_lo   = len[7:0];
  // tx_data always holds the byte being accepted, so the
  // running sum can use it for length and data alike.
  assign csum_add = csum + tx_data;

  // Two-flop synchronizer for test_done plus an edge history flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[1:0], test_done};
    end
  end

  // Frame sequencer with registered memory and stream outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      len        <= '0;
      addr       <= '0;
      csum       <= '0;
      wcnt       <= '0;
      mem_re     <= 1'b0;
      mem_raddr  <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      mem_re     <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (trig) begin
            len      <= last_addr;
            csum     <= '0;
            busy     <= 1'b1;
            tx_data  <= SOF;
            tx_valid <= 1'b1;
            state    <= HDR;
          end
        end
        HDR: begin
          if (accept) begin
            tx_data <= len_hi;
            state   <= LENH;
          end
        end
        LENH: begin
          if (accept) begin
            csum    <= csum_add;
            tx_data <= len_lo;
            state   <= LENL;
          end
        end
        LENL: begin
          if (accept) begin
            csum <= csum_add;
            if (len == '0) begin
              tx_data <= csum_add;
              state   <= CSUM;
            end else begin
              addr      <= ONE;
              mem_re    <= 1'b1;
              mem_raddr <= ONE;
              tx_valid  <= 1'b0;
              state     <= RD;
            end
          end
        end
        RD: begin
          wcnt  <= WAIT_INIT;
          state <= WAIT;
        end
        WAIT: begin
          if (wcnt == '0) begin
            tx_data  <= mem_dout;
            tx_valid <= 1'b1;
            state    <= DATA;
          end else begin
            wcnt <= wcnt - 2'd1;
          end
        end
        DATA: begin
          if (accept) begin
            csum <= csum_add;
            if (addr == len) begin
              tx_data <= csum_add;
              state   <= CSUM;
            end else begin
              addr      <= addr + ONE;
              mem_re    <= 1'b1;
              mem_raddr <= addr + ONE;
              tx_valid  <= 1'b0;
              state     <= RD;
            end
          end
        end
        CSUM: begin
          if (accept) begin
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            state      <= ARM;
          end
        end
        ARM: begin
          if (!sync[1]) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // A stalled byte must not change or vanish.
  a_hold: assert property (
    @(posedge clk) disable iff (!rst)
    tx_valid && !tx_ready |=> tx_valid && $stable(tx_data));

  // Memory reads are single-cycle pulses.
  a_re_pulse: assert property (
    @(posedge clk) disable iff (!rst)
    mem_re |=> !mem_re);

endmodule

// File: tb/tb_result_reader.sv
// tb_result_reader: table-driven frame checks for result_reader
// plus retrigger and mid-frame reset sequences.
module tb_result_reader;

  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          test_done = 1'b0;
  logic [AW-1:0] last_addr = '0;
  logic          mem_re;
  logic [AW-1:0] mem_raddr;
  logic [7:0]    mem_dout = 8'h00;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic          busy;
  logic          frame_done;

  result_reader dut (
    .clk        (clk),
    .rst        (rst),
    .test_done  (test_done),
    .last_addr  (last_addr),
    .mem_re     (mem_re),
    .mem_raddr  (mem_raddr),
    .mem_dout   (mem_dout),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:8191];

  always @(posedge clk) begin
    if (mem_re) mem_dout <= mem[mem_raddr];
  end

  typedef struct {
    logic [AW-1:0] la;
    bit            pat;
    bit            stall;
    int            nbytes;
    logic [7:0]    csum;
    int            nre;
  } vec_t;

  vec_t vt[4];

  int checks = 0;
  int errors = 0;
  int re_cnt = 0;
  int exp_addr = 1;
  int nfd = 0;

  logic [7:0] got[$];
  logic [7:0] expq[$];
  logic [7:0] refq[$];

  task automatic check(input string nm, input int act,
                       input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_re) begin
      check("re_addr", int'(mem_raddr), exp_addr);
      exp_addr++;
      re_cnt++;
    end
  end

  task automatic load_mem(input bit pat);
    for (int i = 0; i < 8192; i++) mem[i] = pat ? 8'(i) : 8'h00;
    if (!pat) begin
      mem[1] = 8'h10;
      mem[2] = 8'h20;
      mem[3] = 8'hF0;
    end
  endtask

  task automatic build_exp(input logic [AW-1:0] la);
    logic [7:0] s;
    expq.delete();
    expq.push_back(8'hA5);
    expq.push_back(8'(la >> 8));
    expq.push_back(la[7:0]);
    s = 8'(la >> 8) + la[7:0];
    for (int i = 1; i <= int'(la); i++) begin
      expq.push_back(mem[i]);
      s = s + mem[i];
    end
    expq.push_back(s);
  endtask

  task automatic cmp_stream();
    check("stream_len", got.size(), expq.size());
    for (int i = 0; i < got.size() && i < expq.size(); i++)
      check($sformatf("byte%0d", i), int'(got[i]), int'(expq[i]));
  endtask

  task automatic run_frame(input logic [AW-1:0] la, input bit stall);
    int         cyc;
    int         first;
    bit         prev_st;
    logic [7:0] prev_d;
    bit         done;
    got.delete();
    re_cnt   = 0;
    exp_addr = 1;
    nfd      = 0;
    first    = -1;
    prev_st  = 1'b0;
    prev_d   = 8'h00;
    done     = 1'b0;
    last_addr = la;
    tx_ready  = 1'b0;
    @(negedge clk);
    test_done = 1'b1;
    cyc = 0;
    while (!done && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 4) last_addr = ~la;
      if (prev_st) begin
        check("stall_valid", int'(tx_valid), 1);
        check("stall_data", int'(tx_data), int'(prev_d));
      end
      if (tx_valid && first < 0) begin
        first = cyc;
        check("first_latency", cyc, 3);
        check("busy_on", int'(busy), 1);
      end
      if (frame_done) begin
        done = 1'b1;
        nfd++;
        check("busy_off", int'(busy), 0);
      end
      tx_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tx_valid && tx_ready) got.push_back(tx_data);
      prev_st = tx_valid && !tx_ready;
      prev_d  = tx_data;
    end
    if (!done) check("frame_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_re"}, int'(mem_re), 0);
    check({tag, "_mem_raddr"}, int'(mem_raddr), 0);
    check({tag, "_tx_data"}, int'(tx_data), 0);
    check({tag, "_tx_valid"}, int'(tx_valid), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_frame_done"}, int'(frame_done), 0);
  endtask

  initial begin
    bit any;
    int cyc;

    vt[0] = '{13'd3,    1'b0, 1'b0, 7,    8'h23, 3};
    vt[1] = '{13'd0,    1'b0, 1'b0, 4,    8'h00, 0};
    vt[2] = '{13'd8191, 1'b1, 1'b0, 8195, 8'h1E, 8191};
    vt[3] = '{13'd3,    1'b0, 1'b1, 7,    8'h23, 3};

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      load_mem(vt[v].pat);
      run_frame(vt[v].la, vt[v].stall);
      build_exp(vt[v].la);
      cmp_stream();
      check("nbytes", got.size(), vt[v].nbytes);
      if (got.size() > 0)
        check("csum", int'(got[got.size()-1]), int'(vt[v].csum));
      check("re_count", re_cnt, vt[v].nre);
      any = 1'b0;
      repeat (10) begin
        @(negedge clk);
        if (tx_valid || busy || mem_re) any = 1'b1;
        if (frame_done) nfd++;
      end
      check("no_retrigger", int'(any), 0);
      check("frame_done_count", nfd, 1);
      if (v == 0) refq = got;
      if (v == 3) begin
        check("refeed_len", got.size(), refq.size());
        for (int i = 0; i < got.size() && i < refq.size(); i++)
          check("refeed_byte", int'(got[i]), int'(refq[i]));
      end
      test_done = 1'b0;
      repeat (4) @(negedge clk);
    end

    load_mem(1'b0);
    re_cnt    = 0;
    exp_addr  = 1;
    last_addr = 13'd3;
    tx_ready  = 1'b1;
    @(negedge clk);
    test_done = 1'b1;
    cyc = 0;
    while (!(tx_valid && re_cnt == 2) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_byte2", int'(tx_valid && re_cnt == 2), 1);
    #1;
    rst = 1'b0;
    test_done = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_after_rst_valid", int'(tx_valid), 0);
    check("idle_after_rst_re", re_cnt, 2);
    run_frame(13'd3, 1'b0);
    build_exp(13'd3);
    cmp_stream();
    check("restart_sof", got.size() > 0 ? int'(got[0]) : -1, 8'hA5);
    test_done = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
